// File: rtl/dac_sched_pkg.sv
// -----------------------------------------------------------------------------
// dac_sched_pkg
// Shared definitions for the DAC sample scheduler: host config word layout,
// the midscale code, the scheduler FSM state type and the per-DAC config
// struct, plus a decoder from the raw config word to that struct.
// Optional feature macro used by the design: DAC_GAIN_EN.
// -----------------------------------------------------------------------------
package dac_sched_pkg;

    // Sample and config word widths
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned CFG_W    = 16;
    localparam int unsigned STREAM_W = 4;
    localparam int unsigned CHAN_W   = 6;
    localparam int unsigned GAIN_W   = 3;

    // Config field offsets inside cfg_data
    localparam int unsigned CFG_EN_BIT     = 0;
    localparam int unsigned CFG_STREAM_LSB = 1;
    localparam int unsigned CFG_CHAN_LSB   = 5;
    localparam int unsigned CFG_GAIN_LSB   = 11;

    // Offset-binary zero: the value an idle or disabled DAC sits at
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } sched_state_t;

    // Per-DAC source selection and gain
    typedef struct packed {
        logic [GAIN_W-1:0]   gain;
        logic [CHAN_W-1:0]   channel;
        logic [STREAM_W-1:0] stream;
        logic                enable;
    } dac_cfg_t;

    // Unpack the host config word into a dac_cfg_t
    function automatic dac_cfg_t cfg_decode(input logic [CFG_W-1:0] d);
        dac_cfg_t c;
        c.enable  = d[CFG_EN_BIT];
        c.stream  = d[CFG_STREAM_LSB +: STREAM_W];
        c.channel = d[CFG_CHAN_LSB +: CHAN_W];
        c.gain    = d[CFG_GAIN_LSB +: GAIN_W];
        return c;
    endfunction

endpackage : dac_sched_pkg

// File: rtl/dac_sched_gain_sat.sv
// -----------------------------------------------------------------------------
// dac_gain_sat
// Combinational midscale-centred gain stage. The offset-binary sample is
// re-centred to signed, shifted left by i_gain (0..7), clamped to the signed
// 16-bit range and converted back to offset binary.
// Only instantiated by dac_sample_scheduler when DAC_GAIN_EN is defined.
// Ports:
//   i_sample  in  16  offset-binary sample
//   i_gain    in  3   left-shift amount
//   o_sample  out 16  shifted, saturated offset-binary sample
// -----------------------------------------------------------------------------
module dac_gain_sat
    import dac_sched_pkg::*;
(
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [GAIN_W-1:0]   i_gain,
    output logic [SAMPLE_W-1:0] o_sample
);

    localparam int unsigned WIDE_W = 24;

    logic signed [WIDE_W-1:0]   w_centred;
    logic signed [WIDE_W-1:0]   w_shifted;
    logic        [SAMPLE_W-1:0] w_clamped;

    // Inverting the MSB of offset binary gives two's complement; sign-extend to 24 bits.
    assign w_centred = {{(WIDE_W-SAMPLE_W){~i_sample[SAMPLE_W-1]}},
                        ~i_sample[SAMPLE_W-1], i_sample[SAMPLE_W-2:0]};

    // 16 + 7 bits fits in 24-bit signed without overflow
    assign w_shifted = w_centred <<< i_gain;

    // Clamp to signed 16-bit range
    always_comb begin
        w_clamped = w_shifted[SAMPLE_W-1:0];
        if (w_shifted > 24'sd32767) begin
            w_clamped = 16'h7FFF;
        end else if (w_shifted < -24'sd32768) begin
            w_clamped = 16'h8000;
        end
    end

    assign o_sample = {~w_clamped[SAMPLE_W-1], w_clamped[SAMPLE_W-2:0]};

endmodule : dac_gain_sat

// File: rtl/dac_sample_scheduler.sv
// -----------------------------------------------------------------------------
// dac_sample_scheduler
// Routes amplifier sample words to NUM_DAC DAC serializers. Each DAC has a
// host-written shadow config, an active config in force for the current
// frame, a pending sample captured during the frame and a committed output.
// Everything visible to the serializers changes only on the first cycle of
// main_state == ms_wait, so values never move mid-shift.
// Optional feature: DAC_GAIN_EN adds a per-DAC shift/saturate stage
// (cfg_data[13:11]) between pending sample and committed value.
// Ports:
//   dataclk       in   1            data clock, rising edge
//   reset         in   1            asynchronous, active high
//   main_state    in   32           main sequencer state
//   cfg_we        in   1            config write strobe
//   cfg_addr      in   3            DAC index for the write
//   cfg_data      in   16           [0] en, [4:1] stream, [10:5] chan, [13:11] gain
//   data_valid    in   1            sample word present
//   data_stream   in   4            source stream of the word
//   data_channel  in   6            source channel of the word
//   data_word     in   16           offset-binary sample
//   dac_register  out  NUM_DAC*16   committed values, DAC i at [16i+15:16i]
//   dac_en        out  NUM_DAC      committed enables
//   frame_commit  out  1            pulse the cycle after a commit edge
// -----------------------------------------------------------------------------
module dac_sample_scheduler
    import dac_sched_pkg::*;
#(
    parameter int unsigned NUM_DAC = 8,
    parameter logic [31:0] ms_wait = 32'd99
) (
    input  logic                      dataclk,
    input  logic                      reset,
    input  logic [31:0]               main_state,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_addr,
    input  logic [CFG_W-1:0]          cfg_data,
    input  logic                      data_valid,
    input  logic [STREAM_W-1:0]       data_stream,
    input  logic [CHAN_W-1:0]         data_channel,
    input  logic [SAMPLE_W-1:0]       data_word,
    output logic [NUM_DAC*SAMPLE_W-1:0] dac_register,
    output logic [NUM_DAC-1:0]        dac_en,
    output logic                      frame_commit
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    sched_state_t r_state;
    sched_state_t w_state_next;
    logic         w_capture;

    logic [31:0]  r_prev_state;
    logic         w_commit;

    dac_cfg_t            r_shadow  [NUM_DAC];
    dac_cfg_t            r_active  [NUM_DAC];
    logic [SAMPLE_W-1:0] r_pending [NUM_DAC];

    logic [NUM_DAC*SAMPLE_W-1:0] r_dac_register;
    logic [NUM_DAC-1:0]          r_dac_en;
    logic                        r_frame_commit;

    dac_cfg_t            w_cfg;
    logic [NUM_DAC-1:0]  w_hit;
    logic [SAMPLE_W-1:0] w_dac_value [NUM_DAC];

    // First cycle of ms_wait; a long ms_wait therefore commits only once.
    assign w_commit = (main_state == ms_wait) && (r_prev_state != ms_wait);

    // Decode the host word; gain is held at zero when the gain stage is absent.
    always_comb begin
        w_cfg = cfg_decode(cfg_data);
`ifndef DAC_GAIN_EN
        w_cfg.gain = '0;
`endif
    end

    // Bits that carry no function in this build
    logic w_unused_cfg;
`ifdef DAC_GAIN_EN
    assign w_unused_cfg = ^cfg_data[CFG_W-1:CFG_GAIN_LSB+GAIN_W];
`else
    logic [NUM_DAC-1:0] w_unused_gain;
    for (genvar g = 0; g < NUM_DAC; g++) begin : g_unused_gain
        assign w_unused_gain[g] = ^r_active[g].gain;
    end
    assign w_unused_cfg = ^{cfg_data[CFG_W-1:CFG_GAIN_LSB], w_unused_gain};
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state and capture enable
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_commit) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_RUN: begin
                w_capture = 1'b1;
                if (w_commit) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_capture    = 1'b1;
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Per-DAC source match and committed-value function
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_DAC; i++) begin : g_dac
        // Match against the active config; on a commit edge this is still the old one.
        assign w_hit[i] = w_capture && data_valid && r_active[i].enable &&
                          (r_active[i].stream  == data_stream) &&
                          (r_active[i].channel == data_channel);

`ifdef DAC_GAIN_EN
        dac_gain_sat u_gain_sat (
            .i_sample (r_pending[i]),
            .i_gain   (r_active[i].gain),
            .o_sample (w_dac_value[i])
        );
`else
        assign w_dac_value[i] = r_pending[i];
`endif
    end

    // -------------------------------------------------------------------------
    // Shadow/active config, pending samples and committed outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DAC; i++) begin
                r_shadow[i]  <= '0;
                r_active[i]  <= '0;
                r_pending[i] <= MIDSCALE;
            end
            r_dac_register <= {NUM_DAC{MIDSCALE}};
            r_dac_en       <= '0;
            r_frame_commit <= 1'b0;
            r_prev_state   <= '0;
        end else begin
            r_prev_state   <= main_state;
            r_frame_commit <= w_commit;
            for (int i = 0; i < NUM_DAC; i++) begin
                if (cfg_we && (cfg_addr == 3'(i))) begin
                    r_shadow[i] <= w_cfg;
                end
                // Outputs reflect the config that was in force during the closing frame.
                if (w_commit) begin
                    r_active[i]                    <= r_shadow[i];
                    r_dac_en[i]                    <= r_active[i].enable;
                    r_dac_register[SAMPLE_W*i +: SAMPLE_W] <=
                        r_active[i].enable ? w_dac_value[i] : MIDSCALE;
                end
                // Last match in a frame wins; no match keeps the previous sample.
                if (w_hit[i]) begin
                    r_pending[i] <= data_word;
                end
            end
        end
    end

    assign dac_register = r_dac_register;
    assign dac_en       = r_dac_en;
    assign frame_commit = r_frame_commit;

endmodule : dac_sample_scheduler

// File: tb/tb_dac_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dac_sample_scheduler
// Directed scenarios followed by randomized frames, every cycle compared
// against a frame-level reference model of shadow/active/pending/committed
// state. Define DAC_GAIN_EN for both bench and RTL to cover the gain stage.
// -----------------------------------------------------------------------------
module tb_dac_sample_scheduler;

    localparam int NDAC    = 8;
    localparam int MS_WAIT = 99;

    logic                 dataclk = 1'b0;
    logic                 reset;
    logic [31:0]          main_state;
    logic                 cfg_we;
    logic [2:0]           cfg_addr;
    logic [15:0]          cfg_data;
    logic                 data_valid;
    logic [3:0]           data_stream;
    logic [5:0]           data_channel;
    logic [15:0]          data_word;
    logic [NDAC*16-1:0]   dac_register;
    logic [NDAC-1:0]      dac_en;
    logic                 frame_commit;

    dac_sample_scheduler #(.NUM_DAC(NDAC), .ms_wait(32'd99)) u_dut (
        .dataclk      (dataclk),
        .reset        (reset),
        .main_state   (main_state),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .data_valid   (data_valid),
        .data_stream  (data_stream),
        .data_channel (data_channel),
        .data_word    (data_word),
        .dac_register (dac_register),
        .dac_en       (dac_en),
        .frame_commit (frame_commit)
    );

    always #5 dataclk = ~dataclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int m_shadow [NDAC];   // raw host config words
    int m_active [NDAC];
    int m_pend   [NDAC];
    int m_reg    [NDAC];
    int m_en     [NDAC];
    int m_fc;
    int m_prev;
    bit m_started;         // a commit has happened since reset

    function automatic int cfg_word(int en, int s, int c, int g);
        return (en & 1) | ((s & 15) << 1) | ((c & 63) << 5) | ((g & 7) << 11);
    endfunction

    function automatic int xfer(int p, int cfg);
`ifdef DAC_GAIN_EN
        int x;
        int y;
        x = p - 32768;
        y = x * (1 << ((cfg >> 11) & 7));
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y + 32768;
`else
        return p + (cfg & 0);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDAC; i++) begin
            m_shadow[i] = 0; m_active[i] = 0; m_pend[i] = 32768;
            m_reg[i] = 32768; m_en[i] = 0;
        end
        m_fc = 0; m_prev = 0; m_started = 0;
    endtask

    task automatic model_step(int ms, int we, int addr, int cd, int dv, int ds, int dch, int dw);
        int  old_act [NDAC];
        bit  commit;
        commit = (ms == MS_WAIT) && (m_prev != MS_WAIT);
        for (int i = 0; i < NDAC; i++) old_act[i] = m_active[i];
        if (commit) begin
            for (int i = 0; i < NDAC; i++) begin
                m_en[i]     = old_act[i] & 1;
                m_reg[i]    = m_en[i] ? xfer(m_pend[i], old_act[i]) : 32768;
                m_active[i] = m_shadow[i];
            end
        end
        if (m_started && dv != 0) begin
            for (int i = 0; i < NDAC; i++) begin
                if ((old_act[i] & 1) != 0 && ((old_act[i] >> 1) & 15) == ds &&
                    ((old_act[i] >> 5) & 63) == dch)
                    m_pend[i] = dw;
            end
        end
        if (we != 0) m_shadow[addr] = cd;
        m_fc = commit ? 1 : 0;
        m_prev = ms;
        if (commit) m_started = 1;
    endtask

    task automatic check_all(input string tag);
        logic [127:0] exp_reg;
        logic [127:0] exp_en;
        exp_reg = '0;
        exp_en  = '0;
        for (int i = 0; i < NDAC; i++) begin
            exp_reg[16*i +: 16] = 16'(m_reg[i]);
            exp_en[i]           = m_en[i][0];
        end
        chk({tag, ".dac_register"}, 128'(dac_register), exp_reg);
        chk({tag, ".dac_en"}, 128'(dac_en), exp_en);
        chk({tag, ".frame_commit"}, 128'(frame_commit), 128'(m_fc));
    endtask

    // One clock: drive at negedge, model at posedge, compare 1 ns later.
    task automatic tick(int ms, int we, int addr, int cd, int dv, int ds, int dch, int dw);
        main_state   = 32'(ms);
        cfg_we       = we[0];
        cfg_addr     = 3'(addr);
        cfg_data     = 16'(cd);
        data_valid   = dv[0];
        data_stream  = 4'(ds);
        data_channel = 6'(dch);
        data_word    = 16'(dw);
        @(posedge dataclk);
        model_step(ms, we, addr, cd, dv, ds, dch, dw);
        #1;
        check_all("cyc");
        @(negedge dataclk);
    endtask

    task automatic idle(int ms);
        tick(ms, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(int addr, int cd);
        tick(10, 1, addr, cd, 0, 0, 0, 0);
    endtask

    task automatic word(int ds, int dch, int dw);
        tick(10, 0, 0, 0, 1, ds, dch, dw);
    endtask

    task automatic commit_frame();
        idle(MS_WAIT);
        idle(11);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        @(negedge dataclk);
        reset = 1'b0;
    endtask

    initial begin
        int frames;
        reset = 1'b1;
        main_state = '0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
        data_valid = 0; data_stream = '0; data_channel = '0; data_word = '0;
        model_reset();
        @(negedge dataclk);
        check_all("por");
        @(negedge dataclk);
        reset = 1'b0;

        // Long ms_wait right after reset: one pulse, midscale, disabled
        for (int k = 0; k < 5; k++) idle(MS_WAIT);
        chk("first_commit_reg", 128'(dac_register), {8{16'h8000}});
        chk("first_commit_en", 128'(dac_en), 128'(0));

        // Configure DAC2 -> (3,17); word lands after the second commit
        idle(10);
        wr(2, cfg_word(1, 3, 17, 0));
        commit_frame();
        chk("dac2_en_after_c1", 128'(dac_en[2]), 128'(0));
        word(3, 17, 16'h1234);
        commit_frame();
        chk("dac2_after_c2", 128'(dac_register[47:32]), 128'(16'h1234));
        chk("dac2_en_after_c2", 128'(dac_en[2]), 128'(1));

        // Last match wins, then held through an empty frame
        word(3, 17, 16'hAAAA);
        word(3, 17, 16'h5555);
        commit_frame();
        chk("dac2_last_wins", 128'(dac_register[47:32]), 128'(16'h5555));
        commit_frame();
        chk("dac2_held", 128'(dac_register[47:32]), 128'(16'h5555));

        // Disable written on the commit cycle: takes effect two commits later
        tick(MS_WAIT, 1, 2, cfg_word(0, 3, 17, 0), 0, 0, 0, 0);
        idle(11);
        chk("dac2_en_wr_on_commit", 128'(dac_en[2]), 128'(1));
        commit_frame();
        chk("dac2_en_c2_after_wr", 128'(dac_en[2]), 128'(1));
        commit_frame();
        chk("dac2_off_reg", 128'(dac_register[47:32]), 128'(16'h8000));
        chk("dac2_off_en", 128'(dac_en[2]), 128'(0));

        // Capture then reset mid-frame; stale sample must never appear
        wr(2, cfg_word(1, 3, 17, 0));
        commit_frame();
        word(3, 17, 16'h4321);
        async_reset();
        chk("rst_reg", 128'(dac_register), {8{16'h8000}});
        wr(2, cfg_word(1, 3, 17, 0));
        commit_frame();
        word(5, 5, 16'h0BAD);
        commit_frame();
        chk("no_stale_reg", 128'(dac_register[47:32]), 128'(16'h8000));
        chk("no_stale_en", 128'(dac_en[2]), 128'(1));

`ifdef DAC_GAIN_EN
        wr(0, cfg_word(1, 1, 2, 2));
        wr(1, cfg_word(1, 1, 3, 3));
        wr(3, cfg_word(1, 1, 4, 3));
        commit_frame();
        word(1, 2, 16'h8100);
        word(1, 3, 16'h9000);
        word(1, 4, 16'h7000);
        commit_frame();
        chk("gain2", 128'(dac_register[15:0]), 128'(16'h8400));
        chk("gain3_sat_hi", 128'(dac_register[31:16]), 128'(16'hFFFF));
        chk("gain3_sat_lo", 128'(dac_register[63:48]), 128'(16'h0000));
`endif

        // Randomized frames against the model
        frames = 60;
        for (int f = 0; f < frames; f++) begin
            int run_len;
            int wait_len;
            run_len  = $urandom_range(12, 3);
            wait_len = $urandom_range(4, 1);
            for (int c = 0; c < run_len; c++) begin
                int we;
                int cd;
                if ($urandom_range(39, 0) == 0) begin
                    async_reset();
                end
                we = ($urandom_range(3, 0) == 0) ? 1 : 0;
                cd = cfg_word($urandom_range(3, 0) != 0 ? 1 : 0, $urandom_range(1, 0),
                              $urandom_range(2, 0), $urandom_range(7, 0))
                     | (int'($urandom_range(3, 0)) << 14);
                tick($urandom_range(20, 0), we, $urandom_range(7, 0), cd,
                     $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(2, 0),
                     $urandom_range(65535, 0));
            end
            for (int c = 0; c < wait_len; c++) begin
                tick(MS_WAIT, ($urandom_range(3, 0) == 0) ? 1 : 0, $urandom_range(7, 0),
                     cfg_word(1, $urandom_range(1, 0), $urandom_range(2, 0), $urandom_range(7, 0)),
                     $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(2, 0),
                     $urandom_range(65535, 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dac_sample_scheduler
